// File: rtl/pe_pkg.sv
// Shared definitions for the PE accumulator drain controller.
//   state_t    : FSM state encoding
//   idx_width  : width of a PE index bus (at least 1 bit)
package pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_FLUSH,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_acc_shadow.sv
// Shadow buffer holding a snapshot of every PE accumulator, plus the
// read mux that selects the word currently being drained.
//   clk, rst_n : clock, async active-low reset (buffer cleared to 0)
//   load       : copy all pe_acc words into the buffer this cycle
//   pe_acc     : flattened PE accumulators, PE k at [k*DATA_WIDTH +: DATA_WIDTH]
//   idx        : word select
//   data       : selected shadow word
module pe_acc_shadow
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PE     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [NUM_PE*DATA_WIDTH-1:0]     pe_acc,
    input  logic [idx_width(NUM_PE)-1:0]     idx,
    output logic [DATA_WIDTH-1:0]            data
);

    logic [DATA_WIDTH-1:0] shadow_q [NUM_PE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PE; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < NUM_PE; k++) begin
                shadow_q[k] <= pe_acc[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign data = shadow_q[idx];

endmodule

// File: rtl/pe_acc_drain.sv
// Job sequencer for a systolic PE array: clears the array, enables the
// feeder for len MAC cycles, waits out the pipeline/skew latency, snapshots
// all PE accumulators and drains them one word at a time over a
// valid/ready handshake.
//   clk, rst_n          : clock, async active-low reset
//   start, len          : job request (honoured in IDLE only) and MAC length
//   pe_acc              : flattened PE accumulator outputs
//   pe_clr, feed_en     : PE array clear, feeder enable
//   out_valid/ready     : result handshake
//   out_data/idx/last   : result word, its PE index, last-word marker
//   busy, done          : not idle; one-cycle completion pulse
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_CLEAR   | single-cycle pe_clr pulse
// ST_FEED    | feed_en high for len cycles
// ST_FLUSH   | NUM_PE+1 cycles for PE pipeline and systolic skew to settle
// ST_CAPTURE | snapshot pe_acc into the shadow buffer
// ST_DRAIN   | emit shadow words 0..NUM_PE-1
module pe_acc_drain
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PE     = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [CNT_WIDTH-1:0]             len,
    input  logic [NUM_PE*DATA_WIDTH-1:0]     pe_acc,
    output logic                             pe_clr,
    output logic                             feed_en,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [idx_width(NUM_PE)-1:0]     out_idx,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);

    localparam int IW = idx_width(NUM_PE);
    localparam int FW = $clog2(NUM_PE + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PE - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [FW-1:0]        flush_q;
    logic [IW-1:0]        idx_q;
    logic                 done_q;
    logic                 accept;
    logic                 last_hs;

    // done is high in the first IDLE cycle; a start there still belongs to
    // the finished job's window and is dropped.
    assign accept  = (state_q == ST_IDLE) && start && !done_q;
    assign last_hs = (state_q == ST_DRAIN) && out_ready && (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pe_clr    = 1'b0;
        feed_en   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                pe_clr  = 1'b1;
                state_d = (len_q != '0) ? ST_FEED : ST_FLUSH;
            end
            ST_FEED: begin
                feed_en = 1'b1;
                if (cnt_q == CNT_WIDTH'(1)) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_q == '0) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (last_hs) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // cnt_q is loaded with len in CLEAR and counts down through FEED, so
    // len = 2^CNT_WIDTH-1 never needs a wider counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            cnt_q   <= '0;
            flush_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            if (accept) len_q <= len;

            if (state_q == ST_CLEAR)     cnt_q <= len_q;
            else if (state_q == ST_FEED) cnt_q <= cnt_q - CNT_WIDTH'(1);

            // Preloaded outside FLUSH; counting NUM_PE..0 gives NUM_PE+1 cycles.
            if (state_q != ST_FLUSH)   flush_q <= FW'(NUM_PE);
            else if (flush_q != '0)    flush_q <= flush_q - FW'(1);

            if (state_q == ST_CAPTURE) begin
                idx_q <= '0;
            end else if (state_q == ST_DRAIN && out_ready) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            end

            done_q <= last_hs;
        end
    end

    pe_acc_shadow #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PE     (NUM_PE)
    ) u_shadow (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == ST_CAPTURE),
        .pe_acc (pe_acc),
        .idx    (idx_q),
        .data   (out_data)
    );

    assign out_idx  = idx_q;
    assign out_last = out_valid && (idx_q == LAST_IDX);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule
